// File: rtl/pc_sequencer.sv
// Program-counter sequencer: variable-width advance, ROB/predictor redirects, post-redirect fetch bubble.
// Optional redirect history buffer enabled by defining PC_HIST_EN.
module pc_sequencer #(
  parameter int unsigned          XLEN             = 32,
  parameter int unsigned          FETCH_WIDTH      = 2,
  parameter int unsigned          INSTR_BYTES      = 4,
  parameter logic [XLEN-1:0]      RESET_VECTOR     = 32'h0000_0000,
  parameter int unsigned          REDIRECT_BUBBLES = 1,
  parameter int unsigned          HIST_DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] inc_count,
  input  logic                            rob_wr,
  input  logic [XLEN-1:0]                 rob_jump_address,
  input  logic                            pred_wr,
  input  logic [XLEN-1:0]                 pred_jump_address,
  input  logic                            delete_tagged,
  output logic [XLEN-1:0]                 address,
  output logic                            address_valid,
  output logic                            misaligned,
  input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
  output logic [XLEN-1:0]                 hist_rd_data
);

  localparam int unsigned IC_W    = $clog2(FETCH_WIDTH+1);
  localparam int unsigned OFS_W   = $clog2(INSTR_BYTES);
  localparam int unsigned HIST_W  = $clog2(HIST_DEPTH);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [2:0] BUB_RELOAD = (REDIRECT_BUBBLES > 0) ? 3'(REDIRECT_BUBBLES - 1) : 3'd0;
  localparam logic [IC_W-1:0] FW_MAX = IC_W'(FETCH_WIDTH);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t            state;
  logic [2:0]        bub_cnt;
  logic              redir_take;
  logic [XLEN-1:0]   redir_tgt;
  logic [XLEN-1:0]   redir_aligned;
  logic              redir_odd;
  logic [IC_W-1:0]   inc_eff;
  logic [XLEN-1:0]   step_bytes;

  // Redirect arbitration: ROB always wins; predictor only counts in RUN and when not flushed.
  always_comb begin
    redir_take = 1'b0;
    redir_tgt  = rob_jump_address;
    if (rob_wr) begin
      redir_take = 1'b1;
    end else if (state == RUN && pred_wr && !delete_tagged) begin
      redir_take = 1'b1;
      redir_tgt  = pred_jump_address;
    end
    redir_aligned = redir_tgt & ~LOW_MASK;
    redir_odd     = |(redir_tgt & LOW_MASK);
  end

  always_comb begin
    inc_eff    = (inc_count > FW_MAX) ? FW_MAX : inc_count;
    step_bytes = XLEN'(inc_eff) << OFS_W;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address       <= RESET_VECTOR;
      address_valid <= 1'b0;
      misaligned    <= 1'b0;
      state         <= BUBBLE;
      bub_cnt       <= '0;
    end else begin
      misaligned <= redir_take && redir_odd;
      case (state)
        RUN: begin
          if (rob_wr) begin
            address <= redir_aligned;
            if (REDIRECT_BUBBLES > 0) begin
              state         <= BUBBLE;
              address_valid <= 1'b0;
              bub_cnt       <= BUB_RELOAD;
            end
          end else if (redir_take) begin
            address <= redir_aligned;
          end else if (!stall) begin
            address <= address + step_bytes;
          end
        end
        BUBBLE: begin
          if (rob_wr) begin
            address <= redir_aligned;
            if (REDIRECT_BUBBLES > 0) begin
              bub_cnt <= BUB_RELOAD;
            end else begin
              state         <= RUN;
              address_valid <= 1'b1;
            end
          end else if (bub_cnt == '0) begin
            state         <= RUN;
            address_valid <= 1'b1;
          end else begin
            bub_cnt <= bub_cnt - 3'd1;
          end
        end
        default: begin
          state         <= BUBBLE;
          address_valid <= 1'b0;
          bub_cnt       <= '0;
        end
      endcase
    end
  end

`ifdef PC_HIST_EN
  logic [XLEN-1:0]   hist_mem [HIST_DEPTH];
  logic [HIST_W-1:0] wr_ptr;
  logic [HIST_W-1:0] rd_ptr;

  // Records the address being abandoned, i.e. the pre-redirect fetch address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_mem <= '{default: '0};
      wr_ptr   <= '0;
    end else if (redir_take) begin
      hist_mem[wr_ptr] <= address;
      wr_ptr           <= wr_ptr + HIST_W'(1);
    end
  end

  always_comb begin
    rd_ptr       = wr_ptr - HIST_W'(1) - hist_rd_idx;
    hist_rd_data = hist_mem[rd_ptr];
  end
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_rd_idx;
  assign hist_rd_data    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps plus randomized traffic vs. a behavioural model.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 2;
  localparam int unsigned IB   = 4;
  localparam int unsigned RB   = 2;
  localparam int unsigned HD   = 8;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  inc_count = 2'd2;
  logic        rob_wr = 1'b0;
  logic [31:0] rob_jump_address = '0;
  logic        pred_wr = 1'b0;
  logic [31:0] pred_jump_address = '0;
  logic        delete_tagged = 1'b0;
  logic [31:0] address;
  logic        address_valid;
  logic        misaligned;
  logic [2:0]  hist_rd_idx = '0;
  logic [31:0] hist_rd_data;

  pc_sequencer #(
    .XLEN(XLEN), .FETCH_WIDTH(FW), .INSTR_BYTES(IB), .RESET_VECTOR(RV),
    .REDIRECT_BUBBLES(RB), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .inc_count(inc_count),
    .rob_wr(rob_wr), .rob_jump_address(rob_jump_address),
    .pred_wr(pred_wr), .pred_jump_address(pred_jump_address),
    .delete_tagged(delete_tagged), .address(address),
    .address_valid(address_valid), .misaligned(misaligned),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_wait = number of invalid cycles still to come (0 means fetch is live).
  logic [31:0] m_addr = RV;
  int          m_wait = 1;
  logic        m_mis  = 1'b0;
  logic [31:0] m_hist [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = RV;
    m_wait = 1;
    m_mis  = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    logic        acc;
    logic [31:0] tgt;
    int          n;
    acc = 1'b0;
    tgt = '0;
    if (m_wait > 0) begin
      if (rob_wr) begin acc = 1'b1; tgt = rob_jump_address; m_wait = RB; end
      else m_wait = m_wait - 1;
    end else if (rob_wr) begin
      acc = 1'b1; tgt = rob_jump_address; m_wait = RB;
    end else if (pred_wr && !delete_tagged) begin
      acc = 1'b1; tgt = pred_jump_address;
    end else if (!stall) begin
      n = (int'(inc_count) > FW) ? FW : int'(inc_count);
      m_addr = m_addr + 32'(n * IB);
    end
    if (acc) begin
      m_hist.push_back(m_addr);
      if (m_hist.size() > HD) void'(m_hist.pop_front());
      m_mis  = (tgt % IB) != 0;
      m_addr = tgt - (tgt % IB);
    end else begin
      m_mis = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_hist(input int idx);
    if (idx < m_hist.size()) return m_hist[m_hist.size() - 1 - idx];
    return 32'h0;
  endfunction

  task automatic check_all();
    chk("address", 64'(address), 64'(m_addr));
    chk("address_valid", 64'(address_valid), 64'(m_wait == 0));
    chk("misaligned", 64'(misaligned), 64'(m_mis));
`ifdef PC_HIST_EN
    chk("hist_rd_data", 64'(hist_rd_data), 64'(model_hist(int'(hist_rd_idx))));
`else
    chk("hist_rd_data_tied", 64'(hist_rd_data), 64'h0);
`endif
  endtask

  task automatic step(input logic r, input logic [31:0] rt, input logic p, input logic [31:0] pt,
                      input logic d, input logic s, input logic [1:0] ic);
    rob_wr = r; rob_jump_address = rt;
    pred_wr = p; pred_jump_address = pt;
    delete_tagged = d; stall = s; inc_count = ic;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    hist_rd_idx = 3'($urandom_range(0, HD - 1));
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_address", 64'(address), 64'(RV));
    chk("rst_valid", 64'(address_valid), 64'h0);
    chk("rst_mis", 64'(misaligned), 64'h0);
    reset = 1'b0;
    #1;
    chk("boot_bubble_valid", 64'(address_valid), 64'h0);

    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("boot_run_valid", 64'(address_valid), 64'h1);
    chk("boot_addr0", 64'(address), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("boot_addr8", 64'(address), 64'h8);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("boot_addr10", 64'(address), 64'h10);

    // ROB beats a same-cycle predictor redirect; misaligned target.
    step(1, 32'h1002, 1, 32'h5000, 0, 0, 2'd2);
    chk("rob_addr", 64'(address), 64'h1000);
    chk("rob_mis", 64'(misaligned), 64'h1);
    chk("rob_bub1", 64'(address_valid), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("rob_mis_clear", 64'(misaligned), 64'h0);
    chk("rob_bub2", 64'(address_valid), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("rob_run_valid", 64'(address_valid), 64'h1);
    chk("rob_run_addr", 64'(address), 64'h1000);

    step(1, 32'h100, 0, 0, 0, 0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 2'd1);
    step(0, 0, 1, 32'h400, 1, 0, 2'd1);
    chk("pred_dropped", 64'(address), 64'h104);
    step(0, 0, 1, 32'h400, 0, 0, 2'd1);
    chk("pred_taken", 64'(address), 64'h400);
    chk("pred_valid", 64'(address_valid), 64'h1);

    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 2'd2);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("wrap", 64'(address), 64'h4);
    step(0, 0, 0, 0, 0, 0, 2'd3);
    chk("clamp", 64'(address), 64'hC);

    step(1, 32'h3000, 0, 0, 0, 0, 2'd2);
    step(1, 32'h2000, 0, 0, 0, 0, 2'd2);
    chk("rebub_addr", 64'(address), 64'h2000);
    chk("rebub_v1", 64'(address_valid), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("rebub_v2", 64'(address_valid), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2);
    chk("rebub_run", 64'(address_valid), 64'h1);

    // Asynchronous reset in the middle of a bubble.
    step(1, 32'h2400, 0, 0, 0, 0, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk("midbub_rst_addr", 64'(address), 64'(RV));
    chk("midbub_rst_valid", 64'(address_valid), 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 16) == 0, $urandom, ($urandom % 4) == 0, $urandom,
           ($urandom % 4) == 0, ($urandom % 5) == 0, 2'($urandom % 4));
    end

    // Asynchronous reset during RUN.
    #1 reset = 1'b1;
    #1;
    chk("midrun_rst_addr", 64'(address), 64'(RV));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 2'd0);

    // Ten consecutive predictor redirects; pre-redirect address of k is target of k-1.
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 32'h1000 + 32'(k) * 32'h40, 0, 0, 2'd1);
    end
`ifdef PC_HIST_EN
    hist_rd_idx = 3'd0;
    #1;
    chk("hist_idx0", 64'(hist_rd_data), 64'(32'h1000 + 32'd8 * 32'h40));
    hist_rd_idx = 3'd7;
    #1;
    chk("hist_idx7", 64'(hist_rd_data), 64'(32'h1000 + 32'd1 * 32'h40));
`else
    hist_rd_idx = 3'd7;
    #1;
    chk("hist_off_idx7", 64'(hist_rd_data), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
